// File: rtl/madder_stream.sv
// madder_stream: streaming LANES-wide signed matrix adder/subtractor with optional
// saturation, row/matrix framing flags and a sticky per-matrix overflow flag.
module madder_stream #(
    parameter int ADDER_NUM    = 128,
    parameter int DIMENTION    = 768,
    parameter int LANES        = 64,
    parameter int WIDTH_ADDEND = 8,
    parameter int WIDTH_SUM    = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            clr,
    input  logic                            op_sub,
    input  logic                            sat_en,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [LANES*WIDTH_ADDEND-1:0]   addend1,
    input  logic [LANES*WIDTH_ADDEND-1:0]   addend2,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [LANES*WIDTH_SUM-1:0]      sum,
    output logic                            out_last_row,
    output logic                            out_last_mat,
    output logic                            ovf
);

    localparam int BEATS = DIMENTION / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int RW    = (ADDER_NUM > 1) ? $clog2(ADDER_NUM) : 1;
    // Wide enough to hold a +/- b exactly and to compare against the result range.
    localparam int EW    = WIDTH_ADDEND + WIDTH_SUM + 2;

    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [RW-1:0] LAST_ROW  = RW'(ADDER_NUM - 1);
    localparam logic signed [EW-1:0] SMAX = {{(EW-WIDTH_SUM+1){1'b0}}, {(WIDTH_SUM-1){1'b1}}};
    localparam logic signed [EW-1:0] SMIN = {{(EW-WIDTH_SUM+1){1'b1}}, {(WIDTH_SUM-1){1'b0}}};

    logic [BW-1:0]                beat_cnt;
    logic [RW-1:0]                row_cnt;
    logic                         mode_sub;
    logic                         mode_sat;
    logic                         accept;
    logic                         first_beat;
    logic                         eff_sub;
    logic                         eff_sat;
    logic                         last_row_now;
    logic                         last_mat_now;
    logic [LANES-1:0]             lane_evt;
    logic [LANES*WIDTH_SUM-1:0]   nxt_sum;

    assign in_ready     = rst_n & ~clr & (~out_valid | out_ready);
    assign accept       = in_valid & in_ready;
    assign first_beat   = (beat_cnt == '0) && (row_cnt == '0);
    assign last_row_now = (beat_cnt == LAST_BEAT);
    assign last_mat_now = last_row_now && (row_cnt == LAST_ROW);

    // The first beat of a matrix already runs in the mode being latched with it.
    assign eff_sub = first_beat ? op_sub : mode_sub;
    assign eff_sat = first_beat ? sat_en : mode_sat;

    always_comb begin
        logic signed [EW-1:0] a_ext;
        logic signed [EW-1:0] b_ext;
        logic signed [EW-1:0] r_ext;
        a_ext    = '0;
        b_ext    = '0;
        r_ext    = '0;
        lane_evt = '0;
        nxt_sum  = '0;
        for (int k = 0; k < LANES; k++) begin
            a_ext = EW'($signed(addend1[k*WIDTH_ADDEND +: WIDTH_ADDEND]));
            b_ext = EW'($signed(addend2[k*WIDTH_ADDEND +: WIDTH_ADDEND]));
            r_ext = eff_sub ? (a_ext - b_ext) : (a_ext + b_ext);
            lane_evt[k] = (r_ext > SMAX) || (r_ext < SMIN);
            if (eff_sat && (r_ext > SMAX)) begin
                nxt_sum[k*WIDTH_SUM +: WIDTH_SUM] = SMAX[WIDTH_SUM-1:0];
            end else if (eff_sat && (r_ext < SMIN)) begin
                nxt_sum[k*WIDTH_SUM +: WIDTH_SUM] = SMIN[WIDTH_SUM-1:0];
            end else begin
                nxt_sum[k*WIDTH_SUM +: WIDTH_SUM] = r_ext[WIDTH_SUM-1:0];
            end
        end
    end

    // Output register, framing counters, mode register and sticky overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_cnt     <= '0;
            row_cnt      <= '0;
            mode_sub     <= 1'b0;
            mode_sat     <= 1'b0;
            out_valid    <= 1'b0;
            sum          <= '0;
            out_last_row <= 1'b0;
            out_last_mat <= 1'b0;
            ovf          <= 1'b0;
        end else if (clr) begin
            beat_cnt  <= '0;
            row_cnt   <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid    <= 1'b1;
            sum          <= nxt_sum;
            out_last_row <= last_row_now;
            out_last_mat <= last_mat_now;
            ovf          <= (first_beat ? 1'b0 : ovf) | (|lane_evt);
            if (first_beat) begin
                mode_sub <= op_sub;
                mode_sat <= sat_en;
            end
            if (last_row_now) begin
                beat_cnt <= '0;
                row_cnt  <= last_mat_now ? '0 : row_cnt + 1'b1;
            end else begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_madder_stream.sv
// tb_madder_stream: scoreboard bench for madder_stream; a cycle model predicts the
// handshake, overflow flag and every result beat, compared in order at the output.
module tb_madder_stream;

    localparam int ADDER_NUM = 128;
    localparam int DIMENTION = 768;
    localparam int LANES     = 64;
    localparam int WA        = 8;
    localparam int WS        = 8;
    localparam int BEATS     = DIMENTION / LANES;
    localparam int MAT       = ADDER_NUM * BEATS;
    localparam int AW        = LANES * WA;
    localparam int SW        = LANES * WS;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          clr       = 1'b0;
    logic          op_sub    = 1'b0;
    logic          sat_en    = 1'b0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b1;
    logic [AW-1:0] addend1   = '0;
    logic [AW-1:0] addend2   = '0;
    logic          in_ready;
    logic          out_valid;
    logic          out_last_row;
    logic          out_last_mat;
    logic          ovf;
    logic [SW-1:0] sum;

    // Small second build where the result is one bit wider than the operands.
    logic          w_rst_n    = 1'b0;
    logic          w_in_valid = 1'b0;
    logic          w_sat_en   = 1'b0;
    logic [15:0]   w_a        = '0;
    logic [15:0]   w_b        = '0;
    logic          w_in_ready;
    logic          w_out_valid;
    logic          w_last_row;
    logic          w_last_mat;
    logic          w_ovf;
    logic [17:0]   w_sum;

    int vecCnt = 0;
    int errCnt = 0;
    int bpMode = 0;

    typedef struct {
        logic [SW-1:0] s;
        logic          lr;
        logic          lm;
    } exp_t;

    exp_t sb[$];
    logic m_ov  = 1'b0;
    logic m_ovf = 1'b0;
    logic m_sub = 1'b0;
    logic m_sat = 1'b0;
    int   m_beat = 0;
    int   m_row  = 0;

    madder_stream #(
        .ADDER_NUM(ADDER_NUM), .DIMENTION(DIMENTION), .LANES(LANES),
        .WIDTH_ADDEND(WA), .WIDTH_SUM(WS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .op_sub(op_sub), .sat_en(sat_en),
        .in_valid(in_valid), .in_ready(in_ready), .addend1(addend1), .addend2(addend2),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .out_last_row(out_last_row), .out_last_mat(out_last_mat), .ovf(ovf)
    );

    madder_stream #(
        .ADDER_NUM(2), .DIMENTION(4), .LANES(2), .WIDTH_ADDEND(8), .WIDTH_SUM(9)
    ) dut_wide (
        .clk(clk), .rst_n(w_rst_n), .clr(1'b0), .op_sub(1'b0), .sat_en(w_sat_en),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .addend1(w_a), .addend2(w_b),
        .out_valid(w_out_valid), .out_ready(1'b1), .sum(w_sum),
        .out_last_row(w_last_row), .out_last_mat(w_last_mat), .ovf(w_ovf)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
        vecCnt++;
        if (obs !== exp) begin
            errCnt++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void modelBeat(input logic [AW-1:0] a, input logic [AW-1:0] b,
                                      input logic sub, input logic sat,
                                      output logic [SW-1:0] s, output logic evt);
        int av, bv, r, res;
        int smax = (1 << (WS - 1)) - 1;
        int smin = -(1 << (WS - 1));
        s   = '0;
        evt = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            av  = $signed(a[k*WA +: WA]);
            bv  = $signed(b[k*WA +: WA]);
            r   = sub ? av - bv : av + bv;
            res = r;
            if (r > smax || r < smin) evt = 1'b1;
            if (sat && r > smax) res = smax;
            if (sat && r < smin) res = smin;
            s[k*WS +: WS] = res[WS-1:0];
        end
    endfunction

    function automatic void genBeat(input int kind, output logic [AW-1:0] a, output logic [AW-1:0] b);
        a = '0;
        b = '0;
        for (int k = 0; k < LANES; k++) begin
            case (kind)
                0: begin a[k*WA +: WA] = 8'd3; b[k*WA +: WA] = 8'd4; end
                1: if (k == 0) begin a[k*WA +: WA] = 8'd100; b[k*WA +: WA] = 8'd100; end
                2: if (k == 0) begin a[k*WA +: WA] = 8'h80; b[k*WA +: WA] = 8'h01; end
                   else begin a[k*WA +: WA] = 8'd5; b[k*WA +: WA] = 8'd2; end
                default: begin a[k*WA +: WA] = WA'($urandom); b[k*WA +: WA] = WA'($urandom); end
            endcase
        end
    endfunction

    // Output monitor and cycle model: compare first, then advance the model for the coming edge.
    always @(negedge clk) begin
        logic expReady, first, evt;
        exp_t e;
        expReady = rst_n & ~clr & (~m_ov | out_ready);
        checkOutput("in_ready", in_ready, expReady);
        checkOutput("out_valid", out_valid, m_ov);
        checkOutput("ovf", ovf, m_ovf);
        if (m_ov && sb.size() > 0) begin
            checkOutput("sum", sum, sb[0].s);
            checkOutput("last_row", out_last_row, sb[0].lr);
            checkOutput("last_mat", out_last_mat, sb[0].lm);
        end
        if (!rst_n) begin
            m_ov = 0; m_ovf = 0; m_sub = 0; m_sat = 0; m_beat = 0; m_row = 0;
            sb.delete();
        end else if (clr) begin
            m_ov = 0; m_ovf = 0; m_beat = 0; m_row = 0;
            sb.delete();
        end else begin
            if (m_ov && out_ready) begin
                if (sb.size() > 0) void'(sb.pop_front());
                m_ov = 0;
            end
            if (in_valid && expReady) begin
                first = (m_beat == 0 && m_row == 0);
                if (first) begin
                    m_sub = op_sub;
                    m_sat = sat_en;
                end
                modelBeat(addend1, addend2, m_sub, m_sat, e.s, evt);
                e.lr  = (m_beat == BEATS - 1);
                e.lm  = e.lr && (m_row == ADDER_NUM - 1);
                m_ovf = first ? evt : (m_ovf | evt);
                sb.push_back(e);
                m_ov = 1;
                if (e.lr) begin
                    m_beat = 0;
                    m_row  = e.lm ? 0 : m_row + 1;
                end else begin
                    m_beat++;
                end
            end
        end
    end

    // Downstream: always ready, random stalls, or fully stalled.
    always @(posedge clk) begin
        #1;
        case (bpMode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    task automatic applyStimulus(input logic [AW-1:0] a, input logic [AW-1:0] b,
                                 input logic sub, input logic sat, input int gap);
        logic acc;
        int   waits;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
        end
        addend1  = a;
        addend2  = b;
        op_sub   = sub;
        sat_en   = sat;
        in_valid = 1'b1;
        acc      = 1'b0;
        waits    = 0;
        while (!acc && waits < 1000) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            waits++;
        end
        if (!acc) checkOutput("accept_timeout", acc, 1'b1);
    endtask

    task automatic sendMatrix(input int kind, input logic sub, input logic sat,
                              input bit toggle, input int maxGap, input int nBeats);
        logic [AW-1:0] a, b;
        for (int i = 0; i < nBeats; i++) begin
            genBeat(kind, a, b);
            applyStimulus(a, b, (toggle && i >= 10) ? ~sub : sub,
                          (toggle && i >= 20) ? ~sat : sat,
                          (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        logic [AW-1:0] a, b;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_sum", sum, '0);
        checkOutput("rst_last_row", out_last_row, 1'b0);
        checkOutput("rst_last_mat", out_last_mat, 1'b0);
        checkOutput("rst_in_ready", in_ready, 1'b0);
        rst_n   = 1'b1;
        w_rst_n = 1'b1;
        @(posedge clk);
        #1;

        sendMatrix(0, 1'b0, 1'b0, 1'b0, 0, MAT);
        checkOutput("m0_sum", sum, {LANES{8'd7}});
        checkOutput("m0_last_mat", out_last_mat, 1'b1);
        checkOutput("m0_ovf", ovf, 1'b0);

        sendMatrix(1, 1'b0, 1'b1, 1'b0, 0, MAT);
        checkOutput("sat_lane0", sum[WS-1:0], 8'd127);
        checkOutput("sat_ovf", ovf, 1'b1);

        sendMatrix(1, 1'b0, 1'b0, 1'b0, 0, MAT);
        checkOutput("wrap_lane0", sum[WS-1:0], 8'hC8);
        checkOutput("wrap_ovf", ovf, 1'b1);

        sendMatrix(2, 1'b1, 1'b1, 1'b1, 0, MAT);
        checkOutput("sub_lane0", sum[WS-1:0], 8'h80);
        checkOutput("sub_lane1", sum[2*WS-1:WS], 8'd3);
        checkOutput("sub_ovf", ovf, 1'b1);

        bpMode = 1;
        sendMatrix(3, 1'($urandom), 1'($urandom), 1'b1, 2, MAT);
        sendMatrix(3, 1'($urandom), 1'($urandom), 1'b1, 2, MAT);
        bpMode = 0;
        repeat (3) @(posedge clk);
        #1;

        sendMatrix(1, 1'b0, 1'b1, 1'b0, 0, 3 * BEATS + 5);
        genBeat(0, a, b);
        addend1  = a;
        addend2  = b;
        clr      = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("clr_out_valid", out_valid, 1'b0);
        checkOutput("clr_ovf", ovf, 1'b0);
        clr      = 1'b0;
        in_valid = 1'b0;
        sendMatrix(0, 1'b0, 1'b0, 1'b0, 0, MAT);
        checkOutput("post_clr_last_mat", out_last_mat, 1'b1);
        checkOutput("post_clr_ovf", ovf, 1'b0);

        w_a        = {8'd127, 8'd127};
        w_b        = {8'd127, 8'd127};
        w_sat_en   = 1'b1;
        w_in_valid = 1'b1;
        checkOutput("wide_ready", w_in_ready, 1'b1);
        @(posedge clk);
        #1;
        w_in_valid = 1'b0;
        checkOutput("wide_valid", w_out_valid, 1'b1);
        checkOutput("wide_sum", w_sum, {9'd254, 9'd254});
        checkOutput("wide_ovf", w_ovf, 1'b0);

        bpMode = 2;
        @(posedge clk);
        #1;
        genBeat(1, a, b);
        applyStimulus(a, b, 1'b0, 1'b1, 0);
        in_valid = 1'b0;
        checkOutput("pre_rst_valid", out_valid, 1'b1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("mid_rst_sum", sum, '0);
        checkOutput("mid_rst_valid", out_valid, 1'b0);
        checkOutput("mid_rst_last_row", out_last_row, 1'b0);
        checkOutput("mid_rst_last_mat", out_last_mat, 1'b0);
        checkOutput("mid_rst_ovf", ovf, 1'b0);
        checkOutput("mid_rst_in_ready", in_ready, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
        $finish;
    end

endmodule
